// File: rtl/sel_a2f.sv
// sel_a2f: transmit-side formatter between the a2f FIFO and the FT600 write FSM.
// Pops packed {Q,I} pairs from the a2f FIFO (1-cycle read latency), sign-extends
// each half into a 32-bit FT word (I at bit 0, Q at QSTART_BIT_INDEX), buffers
// the words in a small circular buffer and presents them as fixed-length packets.
//
// Ports:
//   clk, reset       single clock, synchronous active-high reset
//   fifo_data_i      a2f FIFO read data, valid the cycle after fifo_re_o
//   fifo_empty_i     a2f FIFO empty
//   fifo_enough_i    a2f FIFO holds at least one packet
//   fifo_re_o        a2f FIFO read enable
//   data_o/valid_o   formatted word and its valid
//   ready_i          FT FSM accepts data_o this cycle
//   last_o           data_o is the final word of a packet
//   enough_o         a packet may be started
//   underrun_o       sticky: buffer ran dry in the middle of a packet
//
// state   | meaning
// S_IDLE  | between packets; first accepted word starts a packet
// S_BURST | inside a packet; counts accepted words until the last one
module sel_a2f #(
   parameter int FT_DATA_WIDTH    = 32,
   parameter int IQ_PAIR_WIDTH    = 24,
   parameter int QSTART_BIT_INDEX = 16,
   parameter int PACKET_WORDS     = 32,
   parameter int BUF_DEPTH        = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [IQ_PAIR_WIDTH-1:0] fifo_data_i,
   input  logic                     fifo_empty_i,
   input  logic                     fifo_enough_i,
   output logic                     fifo_re_o,
   output logic [FT_DATA_WIDTH-1:0] data_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic                     last_o,
   output logic                     enough_o,
   output logic                     underrun_o
);

   localparam int HALF   = IQ_PAIR_WIDTH / 2;
   localparam int PTR_W  = $clog2(BUF_DEPTH);
   localparam int OCC_W  = PTR_W + 1;
   localparam int WCNT_W = $clog2(PACKET_WORDS);
   localparam logic [WCNT_W-1:0] LAST_CNT  = WCNT_W'(PACKET_WORDS - 1);
   localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(BUF_DEPTH);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [IQ_PAIR_WIDTH-1:0] r_buf [BUF_DEPTH];
   logic [PTR_W-1:0]         r_wptr;
   logic [PTR_W-1:0]         r_rptr;
   logic [OCC_W-1:0]         r_occ;
   logic                     r_inflight;
   logic [WCNT_W-1:0]        r_wcnt;
   logic                     r_enough;
   logic                     r_underrun;

   logic [OCC_W-1:0]         w_fill;
   logic                     w_push;
   logic                     w_pop;
   logic [IQ_PAIR_WIDTH-1:0] w_head;
   logic [FT_DATA_WIDTH-1:0] w_word;

   // occupancy plus the read already on its way out of the FIFO
   assign w_fill = r_occ + OCC_W'(r_inflight);
   assign w_push = r_inflight;
   assign w_pop  = valid_o && ready_i;
   assign w_head = r_buf[r_rptr];

   assign w_word = {{(FT_DATA_WIDTH-QSTART_BIT_INDEX-HALF){w_head[IQ_PAIR_WIDTH-1]}},
                    w_head[IQ_PAIR_WIDTH-1:HALF],
                    {(QSTART_BIT_INDEX-HALF){w_head[HALF-1]}},
                    w_head[HALF-1:0]};

   assign enough_o   = r_enough;
   assign underrun_o = r_underrun;

   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_pop)           w_state_nxt = S_BURST;
         S_BURST: if (w_pop && last_o) w_state_nxt = S_IDLE;
         default:                      w_state_nxt = S_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      fifo_re_o = !reset && !fifo_empty_i && (w_fill < DEPTH_OCC);
      valid_o   = (r_occ != '0);
      last_o    = (r_state == S_BURST) && (r_wcnt == LAST_CNT) && valid_o;
      data_o    = valid_o ? w_word : '0;
   end

   // buffer storage needs no reset: occupancy gates everything read from it
   always_ff @(posedge clk) begin
      if (w_push && !reset) r_buf[r_wptr] <= fifo_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_occ      <= '0;
         r_inflight <= 1'b0;
         r_wcnt     <= '0;
         r_enough   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_inflight <= fifo_re_o;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
         if (w_pop) begin
            if (r_state == S_IDLE) r_wcnt <= WCNT_W'(1);
            else if (last_o)       r_wcnt <= '0;
            else                   r_wcnt <= r_wcnt + 1'b1;
         end
         r_enough <= (w_state_nxt == S_IDLE) && fifo_enough_i;
         // dry mid-packet: nothing buffered, nothing in flight, nothing to fetch
         if ((r_state == S_BURST) && (r_occ == '0) && !r_inflight && fifo_empty_i)
            r_underrun <= 1'b1;
      end
   end

endmodule
